// File: rtl/spi_slave_regs_if.sv
// 4-wire SPI bus bundle shared by the Wishbone-SPI master and the on-chip register slave.
interface spi_slave_regs_if;
  logic spi_sck;
  logic spi_mosi;
  logic spi_ss;
  logic spi_miso;

  modport master (output spi_sck, output spi_mosi, output spi_ss, input spi_miso);
  modport slave  (input spi_sck, input spi_mosi, input spi_ss, output spi_miso);
endinterface

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave exposing a byte register file via an EEPROM-style command set
// (WREN/WRDI/RDSR/READ/WRITE), with a local read port and a per-write irq pulse.
module spi_slave_regs #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_slave_regs_if.slave   spi,
  output logic              irq,
  input  logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_rdata
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_WRDI  = 8'h04;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sck_q, ss_q;
  logic [1:0]        mosi_q;
  logic              sck_rise, sck_fall, ss_rise, ss_fall;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_sr, tx_sr;
  logic              byte_vld, skip_fall;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              wel_q, op_wr_q, status_q;
  logic [7:0]        mem [DEPTH];

  logic              wel_set, wel_clr, tx_ld, mem_we, addr_ld, addr_inc;
  logic              op_wr_set, status_set;
  logic [7:0]        tx_ld_val;

  // Edges come from stages 2 and 3; stage 2 is the settled level.
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_rise  = ss_q[1] & ~ss_q[2];
  assign ss_fall  = ~ss_q[1] & ss_q[2];
  assign addr_nxt = addr_q + ADDR_ONE;

  assign spi.spi_miso = ~ss_q[1] & tx_sr[7];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    wel_set    = 1'b0;
    wel_clr    = 1'b0;
    tx_ld      = 1'b0;
    tx_ld_val  = 8'h00;
    mem_we     = 1'b0;
    addr_ld    = 1'b0;
    addr_inc   = 1'b0;
    op_wr_set  = 1'b0;
    status_set = 1'b0;
    if (ss_rise) begin
      state_d = S_IDLE;
      wel_clr = op_wr_q;
    end else if (ss_fall) begin
      state_d = S_CMD;
    end else if (byte_vld) begin
      case (state_q)
        S_CMD: begin
          case (rx_sr)
            CMD_WREN:  begin wel_set = 1'b1; state_d = S_IGNORE; end
            CMD_WRDI:  begin wel_clr = 1'b1; state_d = S_IGNORE; end
            CMD_RDSR: begin
              tx_ld      = 1'b1;
              tx_ld_val  = {6'b0, wel_q, 1'b0};
              status_set = 1'b1;
              state_d    = S_RDATA;
            end
            CMD_WRITE: begin op_wr_set = 1'b1; state_d = S_ADDR; end
            CMD_READ:  state_d = S_ADDR;
            default:   state_d = S_IGNORE;
          endcase
        end
        S_ADDR: begin
          addr_ld = 1'b1;
          if (op_wr_q) begin
            state_d = S_WDATA;
          end else begin
            tx_ld     = 1'b1;
            tx_ld_val = mem[rx_sr[ADDR_W-1:0]];
            state_d   = S_RDATA;
          end
        end
        // Address advances even when WEL drops the byte.
        S_WDATA: begin
          mem_we   = wel_q;
          addr_inc = 1'b1;
        end
        S_RDATA: begin
          tx_ld = 1'b1;
          if (status_q) begin
            tx_ld_val = {6'b0, wel_q, 1'b0};
          end else begin
            addr_inc  = 1'b1;
            tx_ld_val = mem[addr_nxt];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q     <= '0;
      ss_q      <= '0;
      mosi_q    <= '0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      byte_vld  <= 1'b0;
      skip_fall <= 1'b0;
      addr_q    <= '0;
      wel_q     <= 1'b0;
      op_wr_q   <= 1'b0;
      status_q  <= 1'b0;
      irq       <= 1'b0;
    end else begin
      sck_q    <= {sck_q[1:0], spi.spi_sck};
      ss_q     <= {ss_q[1:0], spi.spi_ss};
      mosi_q   <= {mosi_q[0], spi.spi_mosi};
      byte_vld <= 1'b0;
      irq      <= mem_we;
      if (ss_rise || ss_fall) begin
        bit_cnt   <= '0;
        rx_sr     <= '0;
        tx_sr     <= '0;
        skip_fall <= 1'b0;
        op_wr_q   <= 1'b0;
        status_q  <= 1'b0;
      end else begin
        if (sck_rise && state_q != S_IDLE) begin
          rx_sr    <= {rx_sr[6:0], mosi_q[1]};
          bit_cnt  <= bit_cnt + 3'd1;
          byte_vld <= (bit_cnt == 3'd7);
        end
        // The fall right after a reload closes the previous byte; keep bit 7 on the pin.
        if (tx_ld) begin
          tx_sr     <= tx_ld_val;
          skip_fall <= 1'b1;
        end else if (sck_fall && state_q != S_IDLE) begin
          if (skip_fall) skip_fall <= 1'b0;
          else           tx_sr     <= {tx_sr[6:0], 1'b0};
        end
        if (op_wr_set)  op_wr_q  <= 1'b1;
        if (status_set) status_q <= 1'b1;
      end
      if (wel_set)      wel_q <= 1'b1;
      else if (wel_clr) wel_q <= 1'b0;
      if (addr_ld)       addr_q <= rx_sr[ADDR_W-1:0];
      else if (addr_inc) addr_q <= addr_nxt;
    end
  end

  // Local read port is write-first against a same-cycle SPI commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      reg_rdata <= 8'h00;
    end else begin
      if (mem_we) mem[addr_q] <= rx_sr;
      reg_rdata <= (mem_we && reg_addr == addr_q) ? rx_sr : mem[reg_addr];
    end
  end
endmodule

// File: tb/tb_spi_slave_regs.sv
// Randomized bench for spi_slave_regs: a frame-level command model predicts miso bytes,
// irq counts and register contents; directed frames pin the model with literal values.
module tb_spi_slave_regs;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       irq;
  logic [3:0] reg_addr = 4'h0;
  logic [7:0] reg_rdata;

  spi_slave_regs_if sif();

  spi_slave_regs #(.ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi      (sif),
    .irq      (irq),
    .reg_addr (reg_addr),
    .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         hp = 5;
  int         irq_cnt = 0;
  logic [7:0] m_mem [16];
  logic       m_wel;
  logic [7:0] fr_tx [16];
  logic [7:0] fr_rx [16];
  logic [7:0] exp_rx [16];
  int         exp_irq;
  logic       chk_en = 1'b0;
  logic       en_s = 1'b0;
  logic [3:0] addr_s = 4'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    addr_s <= reg_addr;
    en_s   <= chk_en;
  end

  always @(negedge clk) begin
    if (irq) irq_cnt <= irq_cnt + 1;
    if (en_s && chk_en) begin
      chk("rdata_vs_model", reg_rdata, m_mem[addr_s]);
      chk("miso_idle", sif.spi_miso, 0);
      chk("irq_idle", irq, 0);
    end
  end

  task automatic set_tx(input logic [7:0] b0, b1, b2, b3);
    for (int i = 0; i < 16; i++) fr_tx[i] = 8'h00;
    fr_tx[0] = b0; fr_tx[1] = b1; fr_tx[2] = b2; fr_tx[3] = b3;
  endtask

  // n full bytes then 'part' bits of fr_tx[n]; optional async reset before bit abort_bit.
  task automatic do_frame(input int n, input int part, input int abort_bit);
    int k;
    k = 0;
    sif.spi_ss = 1'b0;
    tick(hp);
    for (int i = 0; i <= n; i++) begin
      int nb;
      nb = (i < n) ? 8 : part;
      fr_rx[i] = 8'h00;
      for (int b = 0; b < nb; b++) begin
        if (k == abort_bit) begin
          rst = 1'b0;
          #1;
          chk("rst_miso", sif.spi_miso, 0);
          chk("rst_irq", irq, 0);
          chk("rst_rdata", reg_rdata, 0);
          for (int j = 0; j < 16; j++) m_mem[j] = 8'h00;
          m_wel = 1'b0;
          tick(3);
          rst = 1'b1;
        end
        sif.spi_mosi = fr_tx[i][7-b];
        tick(hp);
        fr_rx[i][7-b] = sif.spi_miso;
        sif.spi_sck = 1'b1;
        tick(hp);
        sif.spi_sck = 1'b0;
        k++;
      end
    end
    tick(hp);
    sif.spi_ss   = 1'b1;
    sif.spi_mosi = 1'b0;
    tick(hp + 4);
  endtask

  // Frame-level command semantics applied to the bytes the master sent.
  task automatic model_frame(input int n);
    logic [3:0] a;
    exp_irq = 0;
    for (int i = 0; i < 16; i++) exp_rx[i] = 8'h00;
    if (n < 1) return;
    a = fr_tx[1][3:0];
    case (fr_tx[0])
      8'h06: m_wel = 1'b1;
      8'h04: m_wel = 1'b0;
      8'h05: for (int i = 1; i < n; i++) exp_rx[i] = {6'b0, m_wel, 1'b0};
      8'h02: begin
        for (int i = 2; i < n; i++) begin
          if (m_wel) begin
            m_mem[a] = fr_tx[i];
            exp_irq++;
          end
          a++;
        end
        m_wel = 1'b0;
      end
      8'h03: for (int i = 2; i < n; i++) begin
        exp_rx[i] = m_mem[a];
        a++;
      end
      default: ;
    endcase
  endtask

  task automatic quiet(input int c);
    tick(6);
    chk_en = 1'b1;
    repeat (c) begin
      reg_addr = 4'($urandom);
      tick(1);
    end
    chk_en = 1'b0;
    tick(1);
  endtask

  task automatic run_frame(input int n, input int part, output int dirq);
    int irq0;
    irq0 = irq_cnt;
    do_frame(n, part, -1);
    model_frame(n);
    for (int i = 0; i < n; i++) chk($sformatf("miso_byte%0d", i), fr_rx[i], exp_rx[i]);
    dirq = irq_cnt - irq0;
    chk("irq_count", dirq, exp_irq);
    quiet(8);
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
    reg_addr = a;
    tick(2);
    d = reg_rdata;
  endtask

  initial begin
    int         d, n, part;
    logic [7:0] v;
    sif.spi_sck  = 1'b0;
    sif.spi_mosi = 1'b0;
    sif.spi_ss   = 1'b1;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_wel = 1'b0;

    tick(5);
    chk("reset_miso", sif.spi_miso, 0);
    chk("reset_irq", irq, 0);
    chk("reset_rdata", reg_rdata, 8'h00);
    rst = 1'b1;
    tick(5);

    set_tx(8'h05, 8'h00, 8'h00, 8'h00); run_frame(2, 0, d);
    chk("lit_rdsr_reset", fr_rx[1], 8'h00);

    set_tx(8'h06, 8'h00, 8'h00, 8'h00); run_frame(1, 0, d);
    set_tx(8'h02, 8'h05, 8'hA5, 8'h3C); run_frame(4, 0, d);
    chk("lit_irq_two", d, 2);
    set_tx(8'h05, 8'h00, 8'h00, 8'h00); run_frame(2, 0, d);
    chk("lit_wel_cleared", fr_rx[1], 8'h00);
    rd_reg(4'd5, v); chk("lit_mem5", v, 8'hA5);
    rd_reg(4'd6, v); chk("lit_mem6", v, 8'h3C);

    set_tx(8'h06, 8'h00, 8'h00, 8'h00); run_frame(1, 0, d);
    set_tx(8'h02, 8'h0F, 8'h11, 8'h22); run_frame(4, 0, d);
    set_tx(8'h03, 8'h0F, 8'h00, 8'h00); run_frame(4, 0, d);
    chk("lit_read_wrap0", fr_rx[2], 8'h11);
    chk("lit_read_wrap1", fr_rx[3], 8'h22);
    rd_reg(4'd0, v); chk("lit_mem0_wrap", v, 8'h22);

    set_tx(8'h02, 8'h03, 8'h77, 8'h00); run_frame(3, 0, d);
    chk("lit_nowren_irq", d, 0);
    rd_reg(4'd3, v); chk("lit_mem3_kept", v, 8'h00);
    set_tx(8'h06, 8'h00, 8'h00, 8'h00); run_frame(1, 0, d);
    set_tx(8'h05, 8'h00, 8'h00, 8'h00); run_frame(2, 0, d);
    chk("lit_status_wel", fr_rx[1], 8'h02);

    set_tx(8'h06, 8'h00, 8'h00, 8'h00); run_frame(1, 0, d);
    set_tx(8'h02, 8'h08, 8'hFF, 8'h00); run_frame(2, 5, d);
    chk("lit_partial_irq", d, 0);
    rd_reg(4'd8, v); chk("lit_partial_mem", v, 8'h00);
    set_tx(8'h03, 8'h05, 8'h00, 8'h00); run_frame(3, 0, d);
    chk("lit_after_partial", fr_rx[2], 8'hA5);

    set_tx(8'h9F, 8'h12, 8'h34, 8'h00); run_frame(3, 0, d);
    chk("lit_unknown_b1", fr_rx[1], 8'h00);
    chk("lit_unknown_b2", fr_rx[2], 8'h00);

    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 9))
        0, 1:    fr_tx[0] = 8'h06;
        2:       fr_tx[0] = 8'h04;
        3:       fr_tx[0] = 8'h05;
        4, 5:    fr_tx[0] = 8'h02;
        6, 7:    fr_tx[0] = 8'h03;
        8:       fr_tx[0] = 8'h9F;
        default: fr_tx[0] = 8'($urandom);
      endcase
      for (int i = 1; i < 16; i++) fr_tx[i] = 8'($urandom);
      n    = $urandom_range(1, 6);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      hp   = $urandom_range(4, 7);
      run_frame(n, part, d);
    end

    hp = 5;
    set_tx(8'h06, 8'h00, 8'h00, 8'h00); run_frame(1, 0, d);
    set_tx(8'h02, 8'h05, 8'hA5, 8'h00); run_frame(3, 0, d);
    reg_addr = 4'd5;
    tick(2);
    set_tx(8'h03, 8'h05, 8'h00, 8'h00);
    do_frame(4, 0, 20);
    chk("abort_b0", fr_rx[0], 8'h00);
    chk("abort_b1", fr_rx[1], 8'h00);
    chk("abort_nibble", fr_rx[2][7:4], 4'hA);
    chk("abort_ignored", fr_rx[3], 8'h00);
    quiet(8);
    set_tx(8'h05, 8'h00, 8'h00, 8'h00); run_frame(2, 0, d);
    chk("lit_rdsr_after_rst", fr_rx[1], 8'h00);
    set_tx(8'h03, 8'h05, 8'h00, 8'h00); run_frame(3, 0, d);
    chk("lit_mem_after_rst", fr_rx[2], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
